// File: rtl/mips_mem_pkg.sv
// Shared types and default sizes for the MIPS unified-memory arbiter.
package mips_mem_pkg;

    localparam int unsigned DEF_AW      = 32;
    localparam int unsigned DEF_DW      = 32;
    localparam int unsigned DEF_TIMEOUT = 15;

    typedef enum logic [2:0] {
        StIdle,
        StCpuBusy,
        StDbgBusy,
        StCpuDone,
        StDbgDone
    } arb_state_e;

    typedef enum logic {
        GNT_CPU = 1'b0,
        GNT_DBG = 1'b1
    } gnt_e;

endpackage

// File: rtl/mips_rr_arb2.sv
// Two-requester round-robin picker; the last-grant register only moves when a grant is taken.
module mips_rr_arb2
    import mips_mem_pkg::*;
(
    input  logic CLK,
    input  logic RST_N,
    input  logic req_cpu_i,
    input  logic req_dbg_i,
    input  logic take_i,
    output logic valid_o,
    output gnt_e gnt_o
);

    gnt_e last_q;

    always_comb begin
        valid_o = req_cpu_i | req_dbg_i;
        gnt_o   = GNT_CPU;
        if (req_cpu_i && req_dbg_i) begin
            if (last_q == GNT_CPU) begin
                gnt_o = GNT_DBG;
            end
        end else if (req_dbg_i) begin
            gnt_o = GNT_DBG;
        end
    end

    // Reset to DBG so the CPU wins the first contested grant.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            last_q <= GNT_DBG;
        end else if (take_i && valid_o) begin
            last_q <= gnt_o;
        end
    end

endmodule

// File: rtl/mips_mem_arbiter.sv
// Shares the unified MIPS memory between the CPU controller and a debug/loader port.
// Define MIPS_MEM_ARB_TIMEOUT_EN to abort accesses that see no MEM_READY within TIMEOUT cycles.
module mips_mem_arbiter
    import mips_mem_pkg::*;
#(
    parameter int unsigned AW      = DEF_AW,
    parameter int unsigned DW      = DEF_DW
`ifdef MIPS_MEM_ARB_TIMEOUT_EN
  , parameter int unsigned TIMEOUT = DEF_TIMEOUT
`endif
) (
    input  logic          CLK,
    input  logic          RST_N,
    input  logic          CPU_RD,
    input  logic          CPU_WR,
    input  logic [AW-1:0] CPU_ADDR,
    input  logic [DW-1:0] CPU_WDATA,
    output logic [DW-1:0] CPU_RDATA,
    output logic          CPU_STALL,
    input  logic          DBG_REQ,
    input  logic          DBG_WE,
    input  logic [AW-1:0] DBG_ADDR,
    input  logic [DW-1:0] DBG_WDATA,
    output logic [DW-1:0] DBG_RDATA,
    output logic          DBG_ACK,
    output logic          MEM_EN,
    output logic          MEM_WE,
    output logic [AW-1:0] MEM_ADDR,
    output logic [DW-1:0] MEM_WDATA,
    input  logic [DW-1:0] MEM_RDATA,
    input  logic          MEM_READY,
    output logic          ERR,
    input  logic          ERR_CLR
);

    arb_state_e state_q;
    logic       cpu_req;
    logic       arb_valid;
    gnt_e       arb_gnt;
    logic       timed_out;

    assign cpu_req   = CPU_RD | CPU_WR;
    assign CPU_STALL = cpu_req & (state_q != StCpuDone);

    mips_rr_arb2 u_rr (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .req_cpu_i (cpu_req),
        .req_dbg_i (DBG_REQ),
        .take_i    (state_q == StIdle),
        .valid_o   (arb_valid),
        .gnt_o     (arb_gnt)
    );

`ifdef MIPS_MEM_ARB_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(TIMEOUT + 1);
    logic [CntW-1:0] cnt_q;

    assign timed_out = !MEM_READY && (cnt_q == CntW'(TIMEOUT - 1));

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            cnt_q <= '0;
        end else if (state_q == StIdle) begin
            cnt_q <= '0;
        end else if (state_q == StCpuBusy || state_q == StDbgBusy) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end
`else
    assign timed_out = 1'b0;
`endif

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q   <= StIdle;
            MEM_EN    <= 1'b0;
            MEM_WE    <= 1'b0;
            MEM_ADDR  <= '0;
            MEM_WDATA <= '0;
            CPU_RDATA <= '0;
            DBG_RDATA <= '0;
            DBG_ACK   <= 1'b0;
            ERR       <= 1'b0;
        end else begin
            DBG_ACK <= 1'b0;
            // A set later in this block overrides the clear.
            if (ERR_CLR) begin
                ERR <= 1'b0;
            end
            unique case (state_q)
                StIdle: begin
                    if (arb_valid) begin
                        MEM_EN <= 1'b1;
                        if (arb_gnt == GNT_CPU) begin
                            state_q   <= StCpuBusy;
                            MEM_WE    <= CPU_WR;
                            MEM_ADDR  <= CPU_ADDR;
                            MEM_WDATA <= CPU_WDATA;
                            if (CPU_RD && CPU_WR) begin
                                ERR <= 1'b1;
                            end
                        end else begin
                            state_q   <= StDbgBusy;
                            MEM_WE    <= DBG_WE;
                            MEM_ADDR  <= DBG_ADDR;
                            MEM_WDATA <= DBG_WDATA;
                        end
                    end
                end
                StCpuBusy, StDbgBusy: begin
                    if (MEM_READY || timed_out) begin
                        MEM_EN <= 1'b0;
                        MEM_WE <= 1'b0;
                        if (timed_out) begin
                            ERR <= 1'b1;
                        end
                        if (state_q == StCpuBusy) begin
                            state_q <= StCpuDone;
                            if (!MEM_WE) begin
                                CPU_RDATA <= timed_out ? '0 : MEM_RDATA;
                            end
                        end else begin
                            state_q <= StDbgDone;
                            DBG_ACK <= 1'b1;
                            if (!MEM_WE) begin
                                DBG_RDATA <= timed_out ? '0 : MEM_RDATA;
                            end
                        end
                    end
                end
                StCpuDone, StDbgDone: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mips_mem_arbiter.sv
// Self-checking bench for mips_mem_arbiter with a bench-side memory responder and reference model.
module tb_mips_mem_arbiter;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic        CPU_RD = 1'b0, CPU_WR = 1'b0;
    logic [31:0] CPU_ADDR = '0, CPU_WDATA = '0, CPU_RDATA;
    logic        CPU_STALL;
    logic        DBG_REQ = 1'b0, DBG_WE = 1'b0;
    logic [31:0] DBG_ADDR = '0, DBG_WDATA = '0, DBG_RDATA;
    logic        DBG_ACK;
    logic        MEM_EN, MEM_WE;
    logic [31:0] MEM_ADDR, MEM_WDATA;
    logic [31:0] MEM_RDATA = '0;
    logic        MEM_READY = 1'b0;
    logic        ERR;
    logic        ERR_CLR = 1'b0;

    int vectors = 0;
    int miscompares = 0;

    // Memory device model driven by the bench
    logic [31:0] mem [logic [31:0]];
    int          mem_wait = 0;
    bit          mem_never = 1'b0;
    int          busy_cnt = 0;
    bit          en_prev = 1'b0;

    // Reference model state
    logic [31:0] ref_mem [logic [31:0]];
    logic [31:0] cpu_rd_m = '0, dbg_rd_m = '0;
    bit          last_dbg_m = 1'b1;

    mips_mem_arbiter dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .CPU_RD    (CPU_RD),
        .CPU_WR    (CPU_WR),
        .CPU_ADDR  (CPU_ADDR),
        .CPU_WDATA (CPU_WDATA),
        .CPU_RDATA (CPU_RDATA),
        .CPU_STALL (CPU_STALL),
        .DBG_REQ   (DBG_REQ),
        .DBG_WE    (DBG_WE),
        .DBG_ADDR  (DBG_ADDR),
        .DBG_WDATA (DBG_WDATA),
        .DBG_RDATA (DBG_RDATA),
        .DBG_ACK   (DBG_ACK),
        .MEM_EN    (MEM_EN),
        .MEM_WE    (MEM_WE),
        .MEM_ADDR  (MEM_ADDR),
        .MEM_WDATA (MEM_WDATA),
        .MEM_RDATA (MEM_RDATA),
        .MEM_READY (MEM_READY),
        .ERR       (ERR),
        .ERR_CLR   (ERR_CLR)
    );

    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    // Responder: READY after mem_wait extra cycles of MEM_EN
    always begin
        @(posedge CLK);
        #2;
        if (MEM_EN) begin
            busy_cnt = en_prev ? busy_cnt + 1 : 0;
            en_prev  = 1'b1;
        end else begin
            en_prev = 1'b0;
        end
        MEM_READY = MEM_EN && !mem_never && (busy_cnt == mem_wait);
        if (MEM_READY) begin
            if (MEM_WE) mem[MEM_ADDR] = MEM_WDATA;
            MEM_RDATA = mem.exists(MEM_ADDR) ? mem[MEM_ADDR] : 32'h0;
        end else begin
            MEM_RDATA = $urandom;
        end
    end

    function automatic logic [31:0] ref_read(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : 32'h0;
    endfunction

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle_inputs();
        CPU_RD = 1'b0; CPU_WR = 1'b0; DBG_REQ = 1'b0; DBG_WE = 1'b0; ERR_CLR = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        mem_never = 1'b0;
        mem_wait = 0;
        RST_N = 1'b0;
        step();
        step();
        RST_N = 1'b1;
        cpu_rd_m = '0;
        dbg_rd_m = '0;
        last_dbg_m = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        vectors++; if (MEM_EN !== 1'b0) begin miscompares++; $display("FAIL reset_mem_en got=%b exp=0", MEM_EN); end
        vectors++; if (MEM_WE !== 1'b0) begin miscompares++; $display("FAIL reset_mem_we got=%b exp=0", MEM_WE); end
        vectors++; if (MEM_ADDR !== 32'h0) begin miscompares++; $display("FAIL reset_mem_addr got=%h exp=0", MEM_ADDR); end
        vectors++; if (MEM_WDATA !== 32'h0) begin miscompares++; $display("FAIL reset_mem_wdata got=%h exp=0", MEM_WDATA); end
        vectors++; if (CPU_RDATA !== 32'h0) begin miscompares++; $display("FAIL reset_cpu_rdata got=%h exp=0", CPU_RDATA); end
        vectors++; if (DBG_RDATA !== 32'h0) begin miscompares++; $display("FAIL reset_dbg_rdata got=%h exp=0", DBG_RDATA); end
        vectors++; if (DBG_ACK !== 1'b0) begin miscompares++; $display("FAIL reset_dbg_ack got=%b exp=0", DBG_ACK); end
        vectors++; if (ERR !== 1'b0) begin miscompares++; $display("FAIL reset_err got=%b exp=0", ERR); end
        vectors++; if (CPU_STALL !== 1'b0) begin miscompares++; $display("FAIL reset_stall_idle got=%b exp=0", CPU_STALL); end
        RST_N = 1'b0;
        CPU_RD = 1'b1;
        #1;
        vectors++; if (CPU_STALL !== 1'b1) begin miscompares++; $display("FAIL reset_stall_req got=%b exp=1", CPU_STALL); end
        vectors++; if (MEM_EN !== 1'b0) begin miscompares++; $display("FAIL reset_en_req got=%b exp=0", MEM_EN); end
        do_reset();
    endtask

    task automatic test_cpu_read();
        mem[32'h40] = 32'h8C220004;
        ref_mem[32'h40] = 32'h8C220004;
        CPU_RD = 1'b1; CPU_ADDR = 32'h40; CPU_WDATA = $urandom; mem_wait = 0;
        step();
        vectors++; if (MEM_EN !== 1'b1) begin miscompares++; $display("FAIL cpurd_en_c1 got=%b exp=1", MEM_EN); end
        vectors++; if (MEM_ADDR !== 32'h40) begin miscompares++; $display("FAIL cpurd_addr got=%h exp=40", MEM_ADDR); end
        vectors++; if (MEM_WE !== 1'b0) begin miscompares++; $display("FAIL cpurd_we got=%b exp=0", MEM_WE); end
        vectors++; if (CPU_STALL !== 1'b1) begin miscompares++; $display("FAIL cpurd_stall_c1 got=%b exp=1", CPU_STALL); end
        step();
        cpu_rd_m = ref_read(32'h40);
        vectors++; if (CPU_STALL !== 1'b0) begin miscompares++; $display("FAIL cpurd_stall_c2 got=%b exp=0", CPU_STALL); end
        vectors++; if (CPU_RDATA !== cpu_rd_m) begin miscompares++; $display("FAIL cpurd_data got=%h exp=%h", CPU_RDATA, cpu_rd_m); end
        vectors++; if (MEM_EN !== 1'b0) begin miscompares++; $display("FAIL cpurd_en_c2 got=%b exp=0", MEM_EN); end
        CPU_RD = 1'b0;
        step();
        vectors++; if (MEM_EN !== 1'b0) begin miscompares++; $display("FAIL cpurd_en_c3 got=%b exp=0", MEM_EN); end
    endtask

    task automatic test_dbg_write();
        int we_cnt = 0;
        int ack_cnt = 0;
        int ack_cyc = -1;
        DBG_REQ = 1'b1; DBG_WE = 1'b1; DBG_ADDR = 32'h10; DBG_WDATA = 32'hDEADBEEF; mem_wait = 3;
        for (int k = 1; k <= 7; k++) begin
            step();
            if (MEM_WE === 1'b1) we_cnt++;
            if (DBG_ACK === 1'b1) begin ack_cnt++; ack_cyc = k; end
            if (k == 5) DBG_REQ = 1'b0;
        end
        ref_mem[32'h10] = 32'hDEADBEEF;
        vectors++; if (we_cnt != 4) begin miscompares++; $display("FAIL dbgwr_we_cycles got=%0d exp=4", we_cnt); end
        vectors++; if (ack_cnt != 1) begin miscompares++; $display("FAIL dbgwr_ack_count got=%0d exp=1", ack_cnt); end
        vectors++; if (ack_cyc != 5) begin miscompares++; $display("FAIL dbgwr_ack_cycle got=%0d exp=5", ack_cyc); end
        vectors++; if (CPU_RDATA !== cpu_rd_m) begin miscompares++; $display("FAIL dbgwr_cpu_rdata got=%h exp=%h", CPU_RDATA, cpu_rd_m); end
        vectors++; if (DBG_RDATA !== dbg_rd_m) begin miscompares++; $display("FAIL dbgwr_dbg_rdata got=%h exp=%h", DBG_RDATA, dbg_rd_m); end
        DBG_REQ = 1'b1; DBG_WE = 1'b0; mem_wait = 0;
        step();
        step();
        dbg_rd_m = ref_read(32'h10);
        vectors++; if (DBG_ACK !== 1'b1) begin miscompares++; $display("FAIL dbgrd_ack got=%b exp=1", DBG_ACK); end
        vectors++; if (DBG_RDATA !== dbg_rd_m) begin miscompares++; $display("FAIL dbgrd_data got=%h exp=%h", DBG_RDATA, dbg_rd_m); end
        DBG_REQ = 1'b0;
        step();
    endtask

    task automatic test_round_robin();
        bit g_dbg [4];
        bit last;
        do_reset();
        last = last_dbg_m;
        for (int i = 0; i < 4; i++) begin
            g_dbg[i] = !last;
            last = g_dbg[i];
        end
        CPU_RD = 1'b1; CPU_ADDR = 32'h200; DBG_REQ = 1'b1; DBG_WE = 1'b0; DBG_ADDR = 32'h300;
        for (int k = 1; k <= 12; k++) begin
            int slot = (k - 1) / 3;
            int ph = (k - 1) % 3;
            logic exp_en = (ph == 0);
            logic exp_ack = (ph == 1) && g_dbg[slot];
            logic exp_stall = !((ph == 1) && !g_dbg[slot]);
            logic [31:0] exp_addr = g_dbg[slot] ? 32'h300 : 32'h200;
            step();
            vectors++; if (MEM_EN !== exp_en) begin miscompares++; $display("FAIL rr_en c%0d got=%b exp=%b", k, MEM_EN, exp_en); end
            vectors++; if (DBG_ACK !== exp_ack) begin miscompares++; $display("FAIL rr_ack c%0d got=%b exp=%b", k, DBG_ACK, exp_ack); end
            vectors++; if (CPU_STALL !== exp_stall) begin miscompares++; $display("FAIL rr_stall c%0d got=%b exp=%b", k, CPU_STALL, exp_stall); end
            if (ph == 0) begin
                vectors++; if (MEM_ADDR !== exp_addr) begin miscompares++; $display("FAIL rr_grant c%0d got=%h exp=%h", k, MEM_ADDR, exp_addr); end
            end
        end
        last_dbg_m = last;
        cpu_rd_m = ref_read(32'h200);
        dbg_rd_m = ref_read(32'h300);
        idle_inputs();
        step();
        step();
    endtask

    task automatic test_conflict();
        logic [31:0] w2 = $urandom;
        CPU_RD = 1'b1; CPU_WR = 1'b1; CPU_ADDR = 32'h80; CPU_WDATA = 32'h12345678; mem_wait = 1;
        step();
        vectors++; if (MEM_WE !== 1'b1) begin miscompares++; $display("FAIL conf_we got=%b exp=1", MEM_WE); end
        vectors++; if (MEM_WDATA !== 32'h12345678) begin miscompares++; $display("FAIL conf_wdata got=%h exp=12345678", MEM_WDATA); end
        vectors++; if (ERR !== 1'b1) begin miscompares++; $display("FAIL conf_err_set got=%b exp=1", ERR); end
        step();
        step();
        vectors++; if (CPU_STALL !== 1'b0) begin miscompares++; $display("FAIL conf_done_stall got=%b exp=0", CPU_STALL); end
        CPU_RD = 1'b0; CPU_WR = 1'b0;
        ref_mem[32'h80] = 32'h12345678;
        step();
        vectors++; if (ERR !== 1'b1) begin miscompares++; $display("FAIL conf_err_sticky got=%b exp=1", ERR); end
        ERR_CLR = 1'b1;
        step();
        ERR_CLR = 1'b0;
        vectors++; if (ERR !== 1'b0) begin miscompares++; $display("FAIL conf_err_clr got=%b exp=0", ERR); end
        CPU_RD = 1'b1; CPU_WR = 1'b1; CPU_ADDR = 32'h84; CPU_WDATA = w2; ERR_CLR = 1'b1; mem_wait = 0;
        step();
        ERR_CLR = 1'b0;
        vectors++; if (ERR !== 1'b1) begin miscompares++; $display("FAIL conf_set_wins got=%b exp=1", ERR); end
        step();
        CPU_RD = 1'b0; CPU_WR = 1'b0;
        ref_mem[32'h84] = w2;
        step();
        ERR_CLR = 1'b1;
        step();
        ERR_CLR = 1'b0;
        CPU_RD = 1'b1; CPU_ADDR = 32'h80;
        step();
        step();
        cpu_rd_m = ref_read(32'h80);
        vectors++; if (CPU_RDATA !== cpu_rd_m) begin miscompares++; $display("FAIL conf_readback got=%h exp=%h", CPU_RDATA, cpu_rd_m); end
        CPU_RD = 1'b0;
        step();
    endtask

    task automatic test_random();
        do_reset();
        for (int t = 0; t < 40; t++) begin
            int pat = $urandom_range(0, 2);
            bit use_cpu = (pat != 1);
            bit use_dbg = (pat != 0);
            bit cpu_we = $urandom_range(0, 1);
            bit dbg_we = $urandom_range(0, 1);
            logic [31:0] cpu_addr = 32'h100 + 32'(4 * $urandom_range(0, 7));
            logic [31:0] dbg_addr = 32'h100 + 32'(4 * $urandom_range(0, 7));
            logic [31:0] cpu_wd = $urandom;
            logic [31:0] dbg_wd = $urandom;
            bit ord [2];
            int n;
            bit cpu_pending = use_cpu;
            if (use_cpu && use_dbg) begin
                ord[0] = !last_dbg_m; ord[1] = last_dbg_m; n = 2;
            end else begin
                ord[0] = use_dbg; ord[1] = 1'b0; n = 1;
            end
            CPU_RD = use_cpu && !cpu_we; CPU_WR = use_cpu && cpu_we;
            CPU_ADDR = cpu_addr; CPU_WDATA = cpu_wd;
            DBG_REQ = use_dbg; DBG_WE = dbg_we; DBG_ADDR = dbg_addr; DBG_WDATA = dbg_wd;
            mem_wait = $urandom_range(0, 3);
            for (int s = 0; s < n; s++) begin
                bit g = ord[s];
                logic [31:0] ea = g ? dbg_addr : cpu_addr;
                logic ew = g ? dbg_we : cpu_we;
                logic [31:0] ed = g ? dbg_wd : cpu_wd;
                last_dbg_m = g;
                step();
                vectors++; if (MEM_EN !== 1'b1) begin miscompares++; $display("FAIL rnd_en t%0d got=%b exp=1", t, MEM_EN); end
                vectors++; if (MEM_ADDR !== ea) begin miscompares++; $display("FAIL rnd_addr t%0d got=%h exp=%h", t, MEM_ADDR, ea); end
                vectors++; if (MEM_WE !== ew) begin miscompares++; $display("FAIL rnd_we t%0d got=%b exp=%b", t, MEM_WE, ew); end
                if (ew) begin
                    vectors++; if (MEM_WDATA !== ed) begin miscompares++; $display("FAIL rnd_wdata t%0d got=%h exp=%h", t, MEM_WDATA, ed); end
                end
                for (int j = 0; j < mem_wait; j++) begin
                    step();
                    vectors++; if (MEM_EN !== 1'b1 || MEM_ADDR !== ea) begin miscompares++; $display("FAIL rnd_hold t%0d got=%b/%h exp=1/%h", t, MEM_EN, MEM_ADDR, ea); end
                end
                step();
                vectors++; if (MEM_EN !== 1'b0) begin miscompares++; $display("FAIL rnd_done_en t%0d got=%b exp=0", t, MEM_EN); end
                vectors++; if (DBG_ACK !== g) begin miscompares++; $display("FAIL rnd_ack t%0d got=%b exp=%b", t, DBG_ACK, g); end
                vectors++; if (CPU_STALL !== (cpu_pending && g)) begin miscompares++; $display("FAIL rnd_stall t%0d got=%b exp=%b", t, CPU_STALL, cpu_pending && g); end
                if (!g) begin
                    if (cpu_we) ref_mem[cpu_addr] = cpu_wd;
                    else cpu_rd_m = ref_read(cpu_addr);
                    CPU_RD = 1'b0; CPU_WR = 1'b0; cpu_pending = 1'b0;
                end else begin
                    if (dbg_we) ref_mem[dbg_addr] = dbg_wd;
                    else dbg_rd_m = ref_read(dbg_addr);
                    DBG_REQ = 1'b0;
                end
                vectors++; if (CPU_RDATA !== cpu_rd_m) begin miscompares++; $display("FAIL rnd_cpu_rdata t%0d got=%h exp=%h", t, CPU_RDATA, cpu_rd_m); end
                vectors++; if (DBG_RDATA !== dbg_rd_m) begin miscompares++; $display("FAIL rnd_dbg_rdata t%0d got=%h exp=%h", t, DBG_RDATA, dbg_rd_m); end
                step();
                vectors++; if (MEM_EN !== 1'b0 || DBG_ACK !== 1'b0) begin miscompares++; $display("FAIL rnd_idle t%0d got=%b/%b exp=0/0", t, MEM_EN, DBG_ACK); end
            end
        end
        vectors++; if (ERR !== 1'b0) begin miscompares++; $display("FAIL rnd_err got=%b exp=0", ERR); end
        mem_wait = 0;
    endtask

    task automatic test_reset_mid();
        mem[32'h44] = 32'hA5A50044;
        ref_mem[32'h44] = 32'hA5A50044;
        CPU_RD = 1'b1; CPU_ADDR = 32'h44; mem_never = 1'b1;
        step();
        vectors++; if (MEM_EN !== 1'b1) begin miscompares++; $display("FAIL rstmid_en_busy got=%b exp=1", MEM_EN); end
        step();
        RST_N = 1'b0;
        #1;
        vectors++; if (MEM_EN !== 1'b0) begin miscompares++; $display("FAIL rstmid_en_async got=%b exp=0", MEM_EN); end
        vectors++; if (CPU_STALL !== 1'b1) begin miscompares++; $display("FAIL rstmid_stall got=%b exp=1", CPU_STALL); end
        step();
        RST_N = 1'b1;
        mem_never = 1'b0; mem_wait = 0;
        cpu_rd_m = '0; dbg_rd_m = '0; last_dbg_m = 1'b1;
        step();
        vectors++; if (MEM_EN !== 1'b1) begin miscompares++; $display("FAIL rstmid_regrant got=%b exp=1", MEM_EN); end
        vectors++; if (MEM_ADDR !== 32'h44) begin miscompares++; $display("FAIL rstmid_addr got=%h exp=44", MEM_ADDR); end
        step();
        cpu_rd_m = ref_read(32'h44);
        vectors++; if (CPU_STALL !== 1'b0) begin miscompares++; $display("FAIL rstmid_done got=%b exp=0", CPU_STALL); end
        vectors++; if (CPU_RDATA !== cpu_rd_m) begin miscompares++; $display("FAIL rstmid_data got=%h exp=%h", CPU_RDATA, cpu_rd_m); end
        CPU_RD = 1'b0;
        step();
    endtask

    task automatic test_timeout();
        int bad = 0;
        CPU_RD = 1'b1; CPU_ADDR = 32'h48; mem_never = 1'b1;
`ifdef MIPS_MEM_ARB_TIMEOUT_EN
        for (int k = 1; k <= 15; k++) begin
            step();
            if (MEM_EN !== 1'b1 || CPU_STALL !== 1'b1) bad++;
        end
        vectors++; if (bad != 0) begin miscompares++; $display("FAIL tmo_busy_cycles got=%0d bad exp=0", bad); end
        step();
        vectors++; if (MEM_EN !== 1'b0) begin miscompares++; $display("FAIL tmo_en got=%b exp=0", MEM_EN); end
        vectors++; if (CPU_STALL !== 1'b0) begin miscompares++; $display("FAIL tmo_done got=%b exp=0", CPU_STALL); end
        vectors++; if (ERR !== 1'b1) begin miscompares++; $display("FAIL tmo_err got=%b exp=1", ERR); end
        vectors++; if (CPU_RDATA !== 32'h0) begin miscompares++; $display("FAIL tmo_rdata got=%h exp=0", CPU_RDATA); end
        CPU_RD = 1'b0;
        step();
        mem_never = 1'b0;
`else
        for (int k = 1; k <= 100; k++) begin
            step();
            if (MEM_EN !== 1'b1 || CPU_STALL !== 1'b1) bad++;
        end
        vectors++; if (bad != 0) begin miscompares++; $display("FAIL wait_busy_cycles got=%0d bad exp=0", bad); end
        vectors++; if (ERR !== 1'b0) begin miscompares++; $display("FAIL wait_err got=%b exp=0", ERR); end
        do_reset();
`endif
    endtask

    initial begin
        test_reset();
        test_cpu_read();
        test_dbg_write();
        test_round_robin();
        test_conflict();
        test_random();
        test_reset_mid();
        test_timeout();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
